// File: rtl/wvlt_ibuf_sched_pkg.sv
// Shared wavelet input-buffer definitions: scheduler state encoding, frame
// length (also the input buffer depth) and statistics counter width.
package wvlt_ibuf_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARM,
      ST_READ,
      ST_GAP
   } t_ibuf_sched_state;

   localparam int unsigned WVLT_FRM_WORDS = 128;
   localparam int unsigned WVLT_STAT_W    = 16;

endpackage

// File: rtl/wvlt_ibuf_sched_strobe_align.sv
// Two-stage delay of the decimated strobe, producing the single pulse on
// which the buffer read request is allowed to change.
module wvlt_strobe_align (
   input  logic iclk,
   input  logic irst_n,
   input  logic iclk_ena,
   output logic oupd
);

   logic ena_p0;
   logic ena_p1;

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         ena_p0 <= 1'b0;
         ena_p1 <= 1'b0;
      end else begin
         ena_p0 <= iclk_ena;
         ena_p1 <= ena_p0;
      end
   end

   // A register loaded on this pulse shows its new value while the
   // twice-delayed strobe is high, after the buffer has used the strobe.
   assign oupd = ena_p0 & ~ena_p1;

endmodule

// File: rtl/wvlt_ibuf_sched.sv
// Frame scheduler for the wavelet input buffer: fill, arm, strobe-aligned read.
// Optional statistics counters are built when WVLT_IBUF_SCHED_STAT_EN is defined.
module wvlt_ibuf_sched
   import wvlt_ibuf_sched_pkg::*;
#(
   parameter int unsigned pWORDS = WVLT_FRM_WORDS
`ifdef WVLT_IBUF_SCHED_STAT_EN
  ,parameter int unsigned pW_CNT = WVLT_STAT_W
`endif
) (
   input  logic iclk,
   input  logic irst_n,
   input  logic iclk_ena,
   input  logic ien,
   input  logic ival,
   input  logic icore_rdy,
   output logic osrc_req,
   output logic obuf_wena,
   output logic obuf_req,
   output logic ofrm_start,
   output logic ofrm_done,
   output logic oabort,
   output logic oovr,
   output logic obusy
`ifdef WVLT_IBUF_SCHED_STAT_EN
  ,output logic [pW_CNT-1:0] ofrm_cnt,
   output logic [pW_CNT-1:0] oabort_cnt
`endif
);

   localparam int unsigned WC_W = $clog2(pWORDS) + 1;
   localparam int unsigned SC_W = $clog2(pWORDS);
   localparam int unsigned HALF = pWORDS / 2;

   t_ibuf_sched_state state;
   logic [WC_W-1:0]   wcnt;
   logic [SC_W-1:0]   scnt;
   logic              upd;

   wvlt_strobe_align u_align (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .iclk_ena (iclk_ena),
      .oupd     (upd)
   );

   // Samples are only written while filling; reset masks a coincident sample.
   assign obuf_wena = irst_n & ival & (state == ST_FILL);

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         scnt       <= '0;
         osrc_req   <= 1'b0;
         obuf_req   <= 1'b0;
         ofrm_start <= 1'b0;
         ofrm_done  <= 1'b0;
         oabort     <= 1'b0;
         oovr       <= 1'b0;
         obusy      <= 1'b0;
      end else begin
         ofrm_start <= 1'b0;
         ofrm_done  <= 1'b0;
         oabort     <= 1'b0;
         oovr       <= ival && (state != ST_FILL);
         case (state)
            ST_IDLE: begin
               wcnt <= '0;
               scnt <= '0;
               if (ien && icore_rdy) begin
                  state    <= ST_FILL;
                  osrc_req <= 1'b1;
                  obusy    <= 1'b1;
               end
            end
            ST_FILL: begin
               if (ival) begin
                  osrc_req <= 1'b0;
                  wcnt     <= wcnt + 1'b1;
                  if (wcnt == WC_W'(pWORDS - 1)) state <= ST_ARM;
               end else if (wcnt != '0) begin
                  // The buffer rewinds its write address when enable drops.
                  oabort <= 1'b1;
                  wcnt   <= '0;
                  state  <= ST_IDLE;
                  obusy  <= 1'b0;
               end
            end
            ST_ARM: begin
               if (iclk_ena) state <= ST_READ;
            end
            ST_READ: begin
               if (iclk_ena && obuf_req) begin
                  scnt <= scnt + 1'b1;
                  if (scnt == '0) ofrm_start <= 1'b1;
                  if (scnt == SC_W'(HALF - 1)) ofrm_done <= 1'b1;
               end
               if (upd) begin
                  if (!obuf_req) begin
                     obuf_req <= 1'b1;
                  end else if (scnt == SC_W'(HALF)) begin
                     obuf_req <= 1'b0;
                     state    <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               // A whole strobe period with the request low lets the buffer
               // clear its read address before the next frame.
               if (upd) begin
                  state <= ST_IDLE;
                  obusy <= 1'b0;
                  scnt  <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef WVLT_IBUF_SCHED_STAT_EN
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         ofrm_cnt   <= '0;
         oabort_cnt <= '0;
      end else begin
         if (ofrm_done && !(&ofrm_cnt)) ofrm_cnt <= ofrm_cnt + 1'b1;
         if (oabort && !(&oabort_cnt)) oabort_cnt <= oabort_cnt + 1'b1;
      end
   end
`endif

endmodule
